// File: rtl/imem_arbiter.sv
// Arbitrates a single memory port between instruction fetch and data access,
// with one outstanding transaction, data priority, fetch anti-starvation and flush kill.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module imem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = `DATA_WIDTH,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  input  logic                    if_flush_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [`INSTR_WIDTH-1:0] if_rdata_o,
  input  logic                    dm_req_i,
  input  logic                    dm_we_i,
  input  logic [3:0]              dm_be_i,
  input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
  input  logic [`DATA_WIDTH-1:0]  dm_wdata_i,
  output logic                    dm_gnt_o,
  output logic                    dm_rvalid_o,
  output logic [`DATA_WIDTH-1:0]  dm_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [3:0]              mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [`DATA_WIDTH-1:0]  mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [`DATA_WIDTH-1:0]  mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_DM} state_e;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [2:0] starve_cnt_q, starve_cnt_d;
  logic       kill_q, kill_d;
  logic       if_eff, sel_if, accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      kill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      kill_q       <= kill_d;
    end
  end

  always_comb begin
    if_eff = if_req_i && !if_flush_i;
    sel_if = if_eff && (!dm_req_i || (starve_cnt_q == LIMIT));

    mem_req_o   = !rst && (state_q == IDLE) && (if_eff || dm_req_i);
    mem_we_o    = sel_if ? 1'b0 : dm_we_i;
    mem_be_o    = sel_if ? 4'hF : dm_be_i;
    mem_addr_o  = sel_if ? if_addr_i : dm_addr_i;
    mem_wdata_o = sel_if ? '0 : dm_wdata_i;

    accept   = mem_req_o && mem_gnt_i;
    if_gnt_o = accept && sel_if;
    dm_gnt_o = accept && !sel_if;

    if_rdata_o = mem_rdata_i;
    dm_rdata_o = mem_rdata_i;

    if_rvalid_o  = 1'b0;
    dm_rvalid_o  = 1'b0;
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    kill_d       = kill_q;

    case (state_q)
      IDLE: begin
        // Starvation counts consecutive data wins only while a live fetch waits.
        if (if_gnt_o) begin
          state_d      = WAIT_IF;
          kill_d       = if_flush_i;
          starve_cnt_d = '0;
        end else begin
          if (dm_gnt_o) state_d = WAIT_DM;
          if (!if_req_i)
            starve_cnt_d = '0;
          else if (dm_gnt_o && if_eff && (starve_cnt_q < LIMIT))
            starve_cnt_d = starve_cnt_q + 3'd1;
        end
      end
      WAIT_IF: begin
        if (mem_rvalid_i) begin
          if_rvalid_o = !rst && !kill_q && !if_flush_i;
          kill_d      = 1'b0;
          state_d     = IDLE;
        end else if (if_flush_i) begin
          kill_d = 1'b1;
        end
      end
      WAIT_DM: begin
        if (mem_rvalid_i) begin
          dm_rvalid_o = !rst;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus random traffic, all checked
// each cycle against a transaction-level reference model.
module tb_imem_arbiter;

  localparam int LIM = 4;

  logic        clk, rst;
  logic        if_req_i, if_flush_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        dm_req_i, dm_we_i, dm_gnt_o, dm_rvalid_o;
  logic [3:0]  dm_be_i;
  logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  imem_arbiter #(.ADDR_WIDTH(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the single outstanding transaction, whether its
  // fetch result has been killed, and how many data wins a waiting fetch has seen.
  bit m_busy, m_owner_if, m_killed;
  int m_starve;
  bit m_acc_if, m_acc_dm;
  logic [4:0] last_ctl;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit ifr, input logic [31:0] ifa, input bit fl,
                      input bit dmr, input bit dwe, input logic [3:0] dbe,
                      input logic [31:0] dma, input logic [31:0] dwd,
                      input bit g, input bit rv, input logic [31:0] rd);
    bit e_req, e_ig, e_dg, e_irv, e_drv, pick_if, live_if;
    bit n_busy, n_owner_if, n_killed;
    int n_starve;
    logic [31:0] e_addr, e_wd;
    logic [4:0]  e_wbe;
    @(negedge clk);
    rst = r; if_req_i = ifr; if_addr_i = ifa; if_flush_i = fl;
    dm_req_i = dmr; dm_we_i = dwe; dm_be_i = dbe; dm_addr_i = dma; dm_wdata_i = dwd;
    mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
    #1;
    {e_req, e_ig, e_dg, e_irv, e_drv} = '0;
    n_busy = m_busy; n_owner_if = m_owner_if; n_killed = m_killed; n_starve = m_starve;
    live_if = ifr && !fl;
    pick_if = live_if && (!dmr || m_starve == LIM);
    e_addr = pick_if ? ifa : dma;
    e_wbe  = pick_if ? 5'h0F : {dwe, dbe};
    e_wd   = pick_if ? 32'h0 : dwd;
    if (r) begin
      n_busy = 0; n_killed = 0; n_starve = 0;
    end else if (!m_busy) begin
      e_req = live_if || dmr;
      e_ig  = e_req && g && pick_if;
      e_dg  = e_req && g && !pick_if;
      if (e_ig || e_dg) begin
        n_busy = 1; n_owner_if = e_ig; n_killed = e_ig && fl;
      end
      if (e_ig || !ifr) n_starve = 0;
      else if (e_dg && live_if && m_starve < LIM) n_starve = m_starve + 1;
    end else if (rv) begin
      e_irv  = m_owner_if && !m_killed && !fl;
      e_drv  = !m_owner_if;
      n_busy = 0; n_killed = 0;
    end else if (m_owner_if && fl) begin
      n_killed = 1;
    end
    last_ctl = {mem_req_o, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o};
    check_eq("ctl", last_ctl, {e_req, e_ig, e_dg, e_irv, e_drv});
    check_eq("rdata", {if_rdata_o, dm_rdata_o}, {rd, rd});
    if (e_req) begin
      check_eq("mem_addr", mem_addr_o, e_addr);
      check_eq("mem_we_be", {mem_we_o, mem_be_o}, e_wbe);
      check_eq("mem_wdata", mem_wdata_o, e_wd);
    end
    @(posedge clk);
    m_busy = n_busy; m_owner_if = n_owner_if; m_killed = n_killed; m_starve = n_starve;
    m_acc_if = e_ig; m_acc_dm = e_dg;
  endtask

  task automatic idle_cycle(input bit g, input bit rv, input logic [31:0] rd);
    step(0, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, g, rv, rd);
  endtask

  bit          if_pend, dm_pend, dm_we_r, mem_busy, rnd_rst, rnd_fl, rnd_g, rnd_rv;
  logic [31:0] if_a, dm_a, dm_wd;
  logic [3:0]  dm_be_r;
  int          mem_lat;

  initial begin
    m_busy = 0; m_owner_if = 0; m_killed = 0; m_starve = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h40, 0, 1, 0, 4'hF, 32'h80, 0, 1, 1, 32'h1);
    check_eq("reset_ctl", last_ctl, 5'b00000);

    // Lone fetch with two-cycle memory latency.
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    check_eq("fetch_gnt", last_ctl, 5'b11000);
    idle_cycle(0, 0, 0);
    idle_cycle(0, 1, 32'h00500093);
    check_eq("fetch_rvalid", {last_ctl, if_rdata_o}, {5'b00010, 32'h00500093});

    // Contention: load wins, fetch follows in the next idle cycle.
    step(0, 1, 32'h104, 0, 1, 0, 4'hF, 32'h2000, 0, 1, 0, 0);
    check_eq("cont_dm_first", last_ctl, 5'b10100);
    step(0, 1, 32'h104, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE);
    check_eq("cont_dm_rvalid", last_ctl, 5'b00001);
    step(0, 1, 32'h104, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    check_eq("cont_if_next", last_ctl, 5'b11000);
    idle_cycle(0, 1, 32'h13);

    // Starvation: LIM data grants, then the fetch, then data again.
    for (int i = 0; i < LIM; i++) begin
      step(0, 1, 32'h200, 0, 1, 0, 4'hF, 32'h3000 + 32'(i*4), 0, 1, 0, 0);
      check_eq("starve_dm", last_ctl, 5'b10100);
      step(0, 1, 32'h200, 0, 1, 0, 4'hF, 32'h3000, 0, 0, 1, 32'h5);
    end
    step(0, 1, 32'h200, 0, 1, 0, 4'hF, 32'h3100, 0, 1, 0, 0);
    check_eq("starve_if", last_ctl, 5'b11000);
    step(0, 1, 32'h204, 0, 1, 0, 4'hF, 32'h3100, 0, 0, 1, 32'h7);
    step(0, 1, 32'h204, 0, 1, 0, 4'hF, 32'h3100, 0, 1, 0, 0);
    check_eq("starve_cleared", last_ctl, 5'b10100);
    idle_cycle(0, 1, 32'h9);

    // Flush kills the in-flight fetch; the next fetch is delivered.
    step(0, 1, 32'h300, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_cycle(0, 1, 32'hDEAD);
    check_eq("flush_killed", last_ctl, 5'b00000);
    step(0, 1, 32'h400, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle_cycle(0, 1, 32'hBEEF);
    check_eq("flush_next_ok", last_ctl, 5'b00010);
    step(0, 1, 32'h404, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    check_eq("flush_idle_nothing", last_ctl, 5'b00000);

    // Store under backpressure.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 1, 4'b0011, 32'h500, 32'h1234, 0, 0, 0);
      check_eq("bp_wait", last_ctl, 5'b10000);
    end
    step(0, 0, 0, 0, 1, 1, 4'b0011, 32'h500, 32'h1234, 1, 0, 0);
    check_eq("bp_gnt", last_ctl, 5'b10100);
    idle_cycle(0, 1, 32'h0);
    check_eq("bp_done", last_ctl, 5'b00001);

    // Reset abandons a load; the stray response is ignored.
    step(0, 0, 0, 0, 1, 0, 4'hF, 32'h600, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_cycle(0, 1, 32'h77);
    check_eq("stray_ignored", last_ctl, 5'b00000);
    step(0, 0, 0, 0, 1, 0, 4'hF, 32'h604, 0, 1, 0, 0);
    check_eq("post_reset_gnt", last_ctl, 5'b10100);
    idle_cycle(0, 1, 32'h88);

    // Random traffic with a reactive single-outstanding memory.
    if_pend = 0; dm_pend = 0; mem_busy = 0; mem_lat = 0;
    if_a = 0; dm_a = 0; dm_wd = 0; dm_we_r = 0; dm_be_r = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!if_pend && $urandom_range(2) == 0) begin
        if_pend = 1; if_a = {$urandom_range(16'hFFFF), 2'b00};
      end
      if (!dm_pend && $urandom_range(2) == 0) begin
        dm_pend = 1; dm_a = $urandom; dm_wd = $urandom;
        dm_we_r = $urandom_range(1); dm_be_r = 4'($urandom_range(14) + 1);
      end
      rnd_rst = ($urandom_range(199) == 0);
      rnd_fl  = ($urandom_range(9) == 0);
      rnd_g   = ($urandom_range(3) != 0);
      rnd_rv  = mem_busy ? (mem_lat == 0) : ($urandom_range(19) == 0);
      step(rnd_rst, if_pend, if_a, rnd_fl, dm_pend, dm_we_r, dm_be_r, dm_a, dm_wd,
           rnd_g, rnd_rv, $urandom);
      if (mem_busy) begin
        if (mem_lat == 0) mem_busy = 0;
        else mem_lat--;
      end
      if (m_acc_if) if_pend = 0;
      if (m_acc_dm) dm_pend = 0;
      if (m_acc_if || m_acc_dm) begin
        mem_busy = 1; mem_lat = $urandom_range(3);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
